soc_bus_isolate_ctrl: RTL and testbench

SOC_BUS_ISOLATE_CTRL -- requirements
Module: soc_bus_isolate_ctrl

---
 rtl/soc_bus_pkg.sv | 23 ++
 rtl/soc_bus_txn_counter.sv | 41 ++++
 rtl/soc_bus_isolate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_soc_bus_isolate_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the bus isolation controller.
// The state encoding and the counter-width helper live here so the top
// level and any integrator wrappers agree on them.
package soc_bus_pkg;

    // Isolation controller states
    typedef enum logic [1:0] {
        OPEN     = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } isolate_state_e;

    // Address-channel indices used for per-channel vectors
    localparam int NUM_CH = 2;
    localparam int CH_WR  = 0;
    localparam int CH_RD  = 1;

    // Width needed to hold 0..max_txns inclusive
    function automatic int isolate_cnt_w(input int max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/soc_bus_txn_counter.sv
// Saturating up/down counter of outstanding transactions.
// Increment saturates at MAX_CNT, decrement holds at zero, and a
// simultaneous increment and decrement leaves the count unchanged.
module soc_bus_txn_counter #(
    parameter int MAX_CNT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CNT);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Next count: saturate at the top, hold at zero
    always_comb begin
        cnt_next = cnt_reg;
        if (inc_i && !dec_i && (cnt_reg != MAX_VAL)) begin
            cnt_next = cnt_reg + 1'b1;
        end else if (dec_i && !inc_i && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/soc_bus_isolate_ctrl.sv
// Bus port isolation controller.
// Passes AW/AR handshakes through while OPEN, tracks outstanding writes
// and reads, and on isolate_i drains the port (no new addresses, in-flight
// valids honoured) before reporting ISOLATED.
// Build option: define SOC_BUS_ISOLATE_ERR_EN to include the sticky
// counter-underflow detector on err_o; otherwise err_o is tied low.
module soc_bus_isolate_ctrl
    import soc_bus_pkg::*;
#(
    parameter int MAX_TXNS = 4,
    parameter int CNT_W    = isolate_cnt_w(MAX_TXNS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             isolate_i,
    output logic             isolated_o,
    input  logic             slv_aw_valid_i,
    output logic             slv_aw_ready_o,
    input  logic             slv_ar_valid_i,
    output logic             slv_ar_ready_o,
    output logic             mst_aw_valid_o,
    input  logic             mst_aw_ready_i,
    output logic             mst_ar_valid_o,
    input  logic             mst_ar_ready_i,
    input  logic             b_valid_i,
    input  logic             b_ready_i,
    input  logic             r_valid_i,
    input  logic             r_ready_i,
    input  logic             r_last_i,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_TXNS);

    isolate_state_e    state_reg;
    isolate_state_e    state_next;
    logic              isolated_reg;

    // Per-channel vectors, index CH_WR = AW/B, CH_RD = AR/R
    logic [NUM_CH-1:0] slv_valid;
    logic [NUM_CH-1:0] mst_ready;
    logic [NUM_CH-1:0] resp_done;
    logic [NUM_CH-1:0] pass;
    logic [NUM_CH-1:0] mst_valid;
    logic [NUM_CH-1:0] addr_hs;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] stall_reg;
    logic [NUM_CH-1:0] stall_next;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic              idle;

    assign slv_valid = {slv_ar_valid_i, slv_aw_valid_i};
    assign mst_ready = {mst_ar_ready_i, mst_aw_ready_i};
    // A write completes on a B handshake, a read on its last R beat
    assign resp_done = {r_valid_i & r_ready_i & r_last_i, b_valid_i & b_ready_i};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign full[gi]       = (cnt[gi] == MAX_VAL);
            // A stalled valid always goes through so it is never retracted
            assign pass[gi]       = stall_reg[gi] | ((state_reg == OPEN) & ~full[gi]);
            assign mst_valid[gi]  = slv_valid[gi] & pass[gi];
            assign addr_hs[gi]    = mst_valid[gi] & mst_ready[gi];
            assign stall_next[gi] = mst_valid[gi] & ~mst_ready[gi];

            soc_bus_txn_counter #(
                .MAX_CNT (MAX_TXNS),
                .CNT_W   (CNT_W)
            ) u_cnt (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .inc_i (addr_hs[gi]),
                .dec_i (resp_done[gi]),
                .cnt_o (cnt[gi])
            );
        end
    endgenerate

    assign mst_aw_valid_o = mst_valid[CH_WR];
    assign mst_ar_valid_o = mst_valid[CH_RD];
    assign slv_aw_ready_o = mst_aw_ready_i & pass[CH_WR];
    assign slv_ar_ready_o = mst_ar_ready_i & pass[CH_RD];
    assign wr_cnt_o       = cnt[CH_WR];
    assign rd_cnt_o       = cnt[CH_RD];

    // Port is quiet once nothing is outstanding and no valid is pending
    assign idle = (cnt[CH_WR] == '0) && (cnt[CH_RD] == '0) && (stall_reg == '0);

    // Stall flags track a downstream valid waiting for ready
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_reg <= '0;
        end else begin
            stall_reg <= stall_next;
        end
    end

    // Next-state logic; dropping isolate_i aborts a drain immediately
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OPEN: begin
                if (isolate_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_next = OPEN;
                end else if (idle) begin
                    state_next = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) begin
                    state_next = OPEN;
                end
            end
            default: begin
                state_next = OPEN;
            end
        endcase
    end

    // State register and registered isolation status
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= OPEN;
            isolated_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            isolated_reg <= (state_next == ISOLATED);
        end
    end

    assign isolated_o = isolated_reg;

`ifdef SOC_BUS_ISOLATE_ERR_EN
    logic underflow;
    logic err_reg;

    // A completion with nothing outstanding (and no matching issue) is an underflow
    assign underflow = (resp_done[CH_WR] & ~addr_hs[CH_WR] & (cnt[CH_WR] == '0)) |
                       (resp_done[CH_RD] & ~addr_hs[CH_RD] & (cnt[CH_RD] == '0));

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | underflow;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_soc_bus_isolate_ctrl.sv
// Directed self-checking bench for soc_bus_isolate_ctrl (MAX_TXNS = 4).
module tb_soc_bus_isolate_ctrl;

`ifdef SOC_BUS_ISOLATE_ERR_EN
    localparam logic [31:0] EXP_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       isolate_i;
    logic       isolated_o;
    logic       slv_aw_valid_i;
    logic       slv_aw_ready_o;
    logic       slv_ar_valid_i;
    logic       slv_ar_ready_o;
    logic       mst_aw_valid_o;
    logic       mst_aw_ready_i;
    logic       mst_ar_valid_o;
    logic       mst_ar_ready_i;
    logic       b_valid_i;
    logic       b_ready_i;
    logic       r_valid_i;
    logic       r_ready_i;
    logic       r_last_i;
    logic [2:0] wr_cnt_o;
    logic [2:0] rd_cnt_o;
    logic       err_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    soc_bus_isolate_ctrl #(.MAX_TXNS(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .isolate_i      (isolate_i),
        .isolated_o     (isolated_o),
        .slv_aw_valid_i (slv_aw_valid_i),
        .slv_aw_ready_o (slv_aw_ready_o),
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .mst_aw_valid_o (mst_aw_valid_o),
        .mst_aw_ready_i (mst_aw_ready_i),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .b_valid_i      (b_valid_i),
        .b_ready_i      (b_ready_i),
        .r_valid_i      (r_valid_i),
        .r_ready_i      (r_ready_i),
        .r_last_i       (r_last_i),
        .wr_cnt_o       (wr_cnt_o),
        .rd_cnt_o       (rd_cnt_o),
        .err_o          (err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst_i = 1'b1; isolate_i = 1'b0;
        slv_aw_valid_i = 1'b0; slv_ar_valid_i = 1'b0;
        mst_aw_ready_i = 1'b0; mst_ar_ready_i = 1'b0;
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        tick(); tick();

        // Reset overrides a handshake in the same cycle
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        tick();
        check("rst_override_wr_cnt", 32'(wr_cnt_o), 32'd0);
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0; rst_i = 1'b0;
        settle();
        check("reset_isolated", 32'(isolated_o), 32'd0);
        check("reset_wr_cnt", 32'(wr_cnt_o), 32'd0);
        check("reset_rd_cnt", 32'(rd_cnt_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_aw_valid", 32'(mst_aw_valid_o), 32'd0);

        // OPEN pass-through, fill write count to MAX
        slv_aw_valid_i = 1'b1;
        settle();
        check("open_aw_valid_pass", 32'(mst_aw_valid_o), 32'd1);
        check("open_aw_ready_low", 32'(slv_aw_ready_o), 32'd0);
        mst_aw_ready_i = 1'b1;
        settle();
        check("open_aw_ready_pass", 32'(slv_aw_ready_o), 32'd1);
        tick();
        check("wr_cnt_1", 32'(wr_cnt_o), 32'd1);
        tick(); tick(); tick();
        check("wr_cnt_4", 32'(wr_cnt_o), 32'd4);
        check("full_aw_valid_blocked", 32'(mst_aw_valid_o), 32'd0);
        check("full_aw_ready_blocked", 32'(slv_aw_ready_o), 32'd0);
        tick();
        check("wr_cnt_saturate", 32'(wr_cnt_o), 32'd4);
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        settle();
        check("full_ready_during_b", 32'(slv_aw_ready_o), 32'd0);
        tick();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        settle();
        check("wr_cnt_after_b", 32'(wr_cnt_o), 32'd3);
        check("ready_returns", 32'(slv_aw_ready_o), 32'd1);

        // Simultaneous AW and B handshake at count 3
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        tick();
        check("simul_inc_dec", 32'(wr_cnt_o), 32'd3);
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        tick(); tick(); tick();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        settle();
        check("wr_cnt_drained", 32'(wr_cnt_o), 32'd0);

        // B at count 0: underflow
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        tick();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        settle();
        check("underflow_hold_0", 32'(wr_cnt_o), 32'd0);
        check("underflow_err", 32'(err_o), EXP_ERR);
        tick();
        check("underflow_err_sticky", 32'(err_o), EXP_ERR);

        // Two reads outstanding, then isolate and drain them
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        tick(); tick();
        slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0;
        settle();
        check("rd_cnt_2", 32'(rd_cnt_o), 32'd2);
        isolate_i = 1'b1;
        tick();
        check("drain_isolated_low", 32'(isolated_o), 32'd0);
        slv_ar_valid_i = 1'b1; mst_ar_ready_i = 1'b1;
        settle();
        check("drain_ar_valid_blocked", 32'(mst_ar_valid_o), 32'd0);
        check("drain_ar_ready_blocked", 32'(slv_ar_ready_o), 32'd0);
        r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b0;
        tick();
        check("r_nonlast_no_dec", 32'(rd_cnt_o), 32'd2);
        r_last_i = 1'b1;
        tick();
        check("rd_cnt_1", 32'(rd_cnt_o), 32'd1);
        tick();
        r_valid_i = 1'b0; r_ready_i = 1'b0; r_last_i = 1'b0;
        settle();
        check("rd_cnt_0", 32'(rd_cnt_o), 32'd0);
        check("not_yet_isolated", 32'(isolated_o), 32'd0);
        tick();
        check("isolated_after_drain", 32'(isolated_o), 32'd1);
        check("isolated_ar_blocked", 32'(mst_ar_valid_o), 32'd0);
        slv_ar_valid_i = 1'b0; mst_ar_ready_i = 1'b0; isolate_i = 1'b0;
        tick();
        check("release_isolated_low", 32'(isolated_o), 32'd0);
        slv_ar_valid_i = 1'b1;
        settle();
        check("release_ar_passes", 32'(mst_ar_valid_o), 32'd1);
        slv_ar_valid_i = 1'b0;
        settle();

        // Idle port: isolated two cycles after isolate_i is sampled
        isolate_i = 1'b1;
        tick();
        check("idle_iso_cycle1", 32'(isolated_o), 32'd0);
        tick();
        check("idle_iso_cycle2", 32'(isolated_o), 32'd1);
        isolate_i = 1'b0;
        tick();
        check("idle_release", 32'(isolated_o), 32'd0);

        // Stalled AW valid is held through DRAIN until accepted
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b0;
        tick();
        isolate_i = 1'b1;
        tick();
        check("stall_valid_kept", 32'(mst_aw_valid_o), 32'd1);
        tick();
        check("stall_valid_kept2", 32'(mst_aw_valid_o), 32'd1);
        check("stall_not_isolated", 32'(isolated_o), 32'd0);
        mst_aw_ready_i = 1'b1;
        settle();
        check("stall_ready_pass", 32'(slv_aw_ready_o), 32'd1);
        tick();
        check("stall_wr_cnt_1", 32'(wr_cnt_o), 32'd1);
        check("stall_then_blocked", 32'(mst_aw_valid_o), 32'd0);
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        tick();
        check("stall_pending_not_iso", 32'(isolated_o), 32'd0);
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        tick();
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        settle();
        check("stall_wr_cnt_0", 32'(wr_cnt_o), 32'd0);
        check("stall_iso_wait", 32'(isolated_o), 32'd0);
        tick();
        check("stall_isolated", 32'(isolated_o), 32'd1);
        isolate_i = 1'b0;
        tick();

        // Abort a drain: back to OPEN, never isolated
        slv_aw_valid_i = 1'b1; mst_aw_ready_i = 1'b1;
        tick();
        slv_aw_valid_i = 1'b0; mst_aw_ready_i = 1'b0;
        settle();
        check("abort_wr_cnt_1", 32'(wr_cnt_o), 32'd1);
        isolate_i = 1'b1;
        tick();
        check("abort_drain1", 32'(isolated_o), 32'd0);
        tick();
        check("abort_drain2", 32'(isolated_o), 32'd0);
        isolate_i = 1'b0;
        tick();
        check("abort_open", 32'(isolated_o), 32'd0);
        slv_aw_valid_i = 1'b1;
        settle();
        check("abort_traffic_resumes", 32'(mst_aw_valid_o), 32'd1);
        slv_aw_valid_i = 1'b0;
        tick();
        check("abort_still_open", 32'(isolated_o), 32'd0);

        // Reset discards outstanding count and clears the error flag
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        check("final_rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
        check("final_rst_err", 32'(err_o), 32'd0);
        check("final_rst_isolated", 32'(isolated_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
